// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// A fetch entry pairs an instruction word with the address it was read from.
package fetch_pkg;

    localparam int XLEN  = 32;
    localparam int INS_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [INS_W-1:0] ins;
    } fetch_entry_t;

    // Instructions are word aligned, so the low two bits of any target are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer between the PC/request logic and decode.
// Flush (reset or redirect) wins over push and pop in the same cycle.
import fetch_pkg::*;

module fetch_fifo #(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    output logic [CNT_W-1:0]   count_o,
    output fetch_entry_t       head_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one read per cycle when the
// buffer can absorb the return, and hands {pc, ins} pairs to decode.
import fetch_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PC_o,
    input  logic [31:0] ins,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_ins
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic             pop;
    logic             push;
    logic             flush;
    logic             issue;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // Decode handshake: an entry transfers in any cycle where id_valid and
    // id_ready are both high; while id_valid & ~id_ready the head is held
    // unchanged. A redirect hides the head so nothing stale is consumed.
    assign id_valid = (fifo_count != '0) && !redirect_valid;
    assign pop      = id_valid && id_ready;
    assign push     = req_q;
    assign flush    = rst || redirect_valid;

    // Slots committed after this cycle: buffered entries plus the return now
    // arriving, minus the one leaving. A new fetch needs one more free slot.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(req_q) - (CNT_W + 1)'(pop);
    assign issue     = !rst && !redirect_valid && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    always_comb begin
        pc_d     = pc_q;
        req_d    = 1'b0;
        req_pc_d = req_pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (issue) begin
            req_d    = 1'b1;
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= '0;
        end else begin
            pc_q     <= pc_d;
            req_q    <= req_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign push_entry.pc  = req_pc_q;
    assign push_entry.ins = ins;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (head_entry)
    );

    assign PC_o   = pc_q;
    assign id_pc  = head_entry.pc;
    assign id_ins = head_entry.ins;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed latency/stall/redirect/reset steps plus a
// random phase, all checked against a next-expected-PC stream model.
module tb_fetch_unit;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: default reset PC, fully exercised
  logic        rst, redirect_valid, id_ready;
  logic [31:0] ins_a, redirect_pc;
  logic [31:0] pc_o_a, id_pc_a, id_ins_a;
  logic        id_valid_a;

  // instance B: reset PC near the top of the address space, streaming only
  logic        rst_b, redirect_b, ready_b;
  logic [31:0] ins_b, redirect_pc_b;
  logic [31:0] pc_o_b, id_pc_b, id_ins_b;
  logic        id_valid_b;

  fetch_unit #(.RESET_PC(RST_A), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .PC_o(pc_o_a), .ins(ins_a),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid_a), .id_ready(id_ready), .id_pc(id_pc_a), .id_ins(id_ins_a)
  );

  fetch_unit #(.RESET_PC(RST_B), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .PC_o(pc_o_b), .ins(ins_b),
    .redirect_valid(redirect_b), .redirect_pc(redirect_pc_b),
    .id_valid(id_valid_b), .id_ready(ready_b), .id_pc(id_pc_b), .id_ins(id_ins_b)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc_a;       // next PC decode must receive from A
  logic [31:0] exp_q[$];       // expected PC stream from B
  logic [31:0] last_a, last_b;
  int          ready_run = 0;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_pc, hold_ins;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the memory model returns the word for last cycle's PC.
  task automatic tick();
    last_a = pc_o_a;
    last_b = pc_o_b;
    @(posedge clk);
    #1;
    ins_a = memf(last_a);
    ins_b = memf(last_b);
  endtask

  // Mid-cycle observation with the stream scoreboard and handshake rules.
  task automatic observe();
    logic [31:0] e;
    #3;
    if (rst) begin
      exp_pc_a  = RST_A;
      ready_run = 0;
      hold_pend = 1'b0;
    end else if (redirect_valid) begin
      chk("redirect_hides_valid", 32'(id_valid_a), 32'd0);
      exp_pc_a  = {redirect_pc[31:2], 2'b00};
      ready_run = 0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(id_valid_a), 32'd1);
        chk("hold_pc", id_pc_a, hold_pc);
        chk("hold_ins", id_ins_a, hold_ins);
      end
      // issued-but-not-consumed fetches never exceed the buffer depth
      chk("inflight_bound", 32'((pc_o_a - exp_pc_a) <= 32'd8), 32'd1);
      ready_run = id_ready ? ready_run + 1 : 0;
      if (ready_run >= 3) chk("liveness", 32'(id_valid_a), 32'd1);
      if (id_valid_a && id_ready) begin
        chk("pop_pc", id_pc_a, exp_pc_a);
        chk("pop_ins", id_ins_a, memf(exp_pc_a));
        exp_pc_a = exp_pc_a + 32'd4;
      end
      hold_pend = id_valid_a && !id_ready;
      hold_pc   = id_pc_a;
      hold_ins  = id_ins_a;
    end
    if (!rst_b && id_valid_b && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("b_pop_pc", id_pc_b, e);
      chk("b_pop_ins", id_ins_b, memf(e));
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0; ins_a = '0;
    rst_b = 1'b1; redirect_b = 1'b0; redirect_pc_b = '0; ready_b = 1'b1; ins_b = '0;
    exp_pc_a = RST_A;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);

    // reset state
    tick(); tick();
    observe();
    chk("reset_pc_a", pc_o_a, RST_A);
    chk("reset_valid_a", 32'(id_valid_a), 32'd0);
    chk("reset_pc_b", pc_o_b, RST_B);
    chk("reset_valid_b", 32'(id_valid_b), 32'd0);
    tick();

    // streaming with id_ready high: first entry in cycle 2, then one per cycle
    rst = 1'b0; rst_b = 1'b0; id_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      observe();
      chk("stream_pc_o", pc_o_a, 32'(4 * c));
      chk("stream_valid", 32'(id_valid_a), 32'(c >= 2));
      if (c >= 2) chk("stream_id_pc", id_pc_a, 32'(4 * (c - 2)));
      chk("b_valid", 32'(id_valid_b), 32'(c >= 2));
      tick();
    end
    chk("b_stream_drained", 32'(exp_q.size()), 32'd0);

    // fresh reset, then decode stalls for 10 cycles
    rst = 1'b1;
    observe();
    tick();
    rst = 1'b0; id_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      observe();
      chk("stall_valid", 32'(id_valid_a), 32'(c >= 2));
      if (c >= 2) begin
        chk("stall_pc_o", pc_o_a, 32'h8);
        chk("stall_head", id_pc_a, 32'h0);
      end
      tick();
    end
    id_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin observe(); tick(); end
    id_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin observe(); tick(); end

    // redirect while the buffer is full
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; id_ready = 1'b1;
    observe();
    chk("full_redirect_valid", 32'(id_valid_a), 32'd0);
    tick();
    redirect_valid = 1'b0;
    observe();
    chk("redirect_pc_o", pc_o_a, 32'h100);
    tick(); observe(); tick(); observe();
    chk("redirect_first_valid", 32'(id_valid_a), 32'd1);
    chk("redirect_first_pc", id_pc_a, 32'h100);
    chk("redirect_first_ins", id_ins_a, memf(32'h100));
    tick();
    for (int c = 0; c < 3; c++) begin observe(); tick(); end

    // back-to-back redirects: only the second target survives
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    observe(); tick();
    redirect_pc = 32'h80;
    observe(); tick();
    redirect_valid = 1'b0;
    observe();
    chk("b2b_pc_o", pc_o_a, 32'h80);
    tick(); observe(); tick(); observe();
    chk("b2b_first_pc", id_pc_a, 32'h80);
    chk("b2b_first_valid", 32'(id_valid_a), 32'd1);
    tick();

    // reset pulse with a full buffer
    id_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin observe(); tick(); end
    rst = 1'b1;
    observe(); tick();
    rst = 1'b0; id_ready = 1'b1;
    observe();
    chk("rst_pulse_pc_o", pc_o_a, RST_A);
    chk("rst_pulse_valid", 32'(id_valid_a), 32'd0);
    tick(); observe(); tick(); observe();
    chk("rst_pulse_first_pc", id_pc_a, RST_A);
    chk("rst_pulse_first_ins", id_ins_a, memf(RST_A));
    tick();

    // randomized ready / redirect / reset
    for (int c = 0; c < 600; c++) begin
      int r;
      r = $urandom_range(0, 99);
      rst            = (r < 2);
      redirect_valid = (r >= 2) && (r < 10);
      redirect_pc    = $urandom;
      id_ready       = ($urandom_range(0, 3) != 0);
      observe();
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
